// File: rtl/reg_file_pkg.sv
// Shared widths and helpers for the architectural register file and its read ports.
package reg_file_pkg;
   localparam int ROB_W_DEF = 3;
   localparam int NREG_DEF  = 32;
   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 32;

   // x0 is hardwired zero, so index 0 never names a real write target.
   function automatic logic is_write(input logic [REG_IDX_W-1:0] id);
      return id != '0;
   endfunction
endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand resolver: x0, same-cycle commit bypass, ROB bypass, pending tag, or stored value.
module reg_read_port
   import reg_file_pkg::*;
#(
   parameter int ROB_W = ROB_W_DEF
) (
   input  logic [REG_IDX_W-1:0] id,
   input  logic [REG_IDX_W-1:0] set_id,
   input  logic [XLEN-1:0]      set_val,
   input  logic [ROB_W-1:0]     set_from_rob_id,
   input  logic                 busy,
   input  logic [ROB_W-1:0]     tag,
   input  logic [XLEN-1:0]      reg_val,
   input  logic                 rob_avail,
   input  logic [XLEN-1:0]      rob_val,
   output logic [XLEN-1:0]      val,
   output logic                 has_dep,
   output logic [ROB_W-1:0]     dep
);
   always_comb begin
      val     = '0;
      has_dep = 1'b0;
      dep     = '0;
      if (!is_write(id)) begin
         val = '0;
      end else if (set_id == id && busy && tag == set_from_rob_id) begin
         val = set_val;
      end else if (busy && rob_avail) begin
         val = rob_val;
      end else if (busy) begin
         has_dep = 1'b1;
         dep     = tag;
      end else begin
         val = reg_val;
      end
   end
endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags; consumes ROB commits/renames and serves two operand reads.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int ROB_W = ROB_W_DEF,
   parameter int NREG  = NREG_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 rob_clear,
   input  logic [REG_IDX_W-1:0] set_id,
   input  logic [XLEN-1:0]      set_val,
   input  logic [ROB_W-1:0]     set_from_rob_id,
   input  logic [REG_IDX_W-1:0] set_dep_id,
   input  logic [ROB_W-1:0]     set_dep_Q,
   input  logic [REG_IDX_W-1:0] rs1_id,
   input  logic [REG_IDX_W-1:0] rs2_id,
   output logic [ROB_W-1:0]     get_rob_id_1,
   output logic [ROB_W-1:0]     get_rob_id_2,
   input  logic                 rob_avail_1,
   input  logic                 rob_avail_2,
   input  logic [XLEN-1:0]      rob_val_1,
   input  logic [XLEN-1:0]      rob_val_2,
   output logic [XLEN-1:0]      rs1_val,
   output logic [XLEN-1:0]      rs2_val,
   output logic                 rs1_has_dep,
   output logic                 rs2_has_dep,
   output logic [ROB_W-1:0]     rs1_dep,
   output logic [ROB_W-1:0]     rs2_dep
);
   logic [XLEN-1:0]  val_q  [NREG];
   logic             busy_q [NREG];
   logic [ROB_W-1:0] tag_q  [NREG];

   // Commit clears busy only when it is the rename still outstanding; a same-cycle rename overrides it.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
               val_q[i]  <= '0;
               busy_q[i] <= 1'b0;
               tag_q[i]  <= '0;
            end
         end else if (rob_clear) begin
            for (int i = 0; i < NREG; i++) begin
               busy_q[i] <= 1'b0;
               tag_q[i]  <= '0;
            end
         end else begin
            if (is_write(set_id)) begin
               val_q[set_id] <= set_val;
               if (tag_q[set_id] == set_from_rob_id)
                  busy_q[set_id] <= 1'b0;
            end
            if (is_write(set_dep_id)) begin
               busy_q[set_dep_id] <= 1'b1;
               tag_q[set_dep_id]  <= set_dep_Q;
            end
         end
      end
   end

   assign get_rob_id_1 = tag_q[rs1_id];
   assign get_rob_id_2 = tag_q[rs2_id];

   reg_read_port #(.ROB_W(ROB_W)) u_rd1 (
      .id              (rs1_id),
      .set_id          (set_id),
      .set_val         (set_val),
      .set_from_rob_id (set_from_rob_id),
      .busy            (busy_q[rs1_id]),
      .tag             (tag_q[rs1_id]),
      .reg_val         (val_q[rs1_id]),
      .rob_avail       (rob_avail_1),
      .rob_val         (rob_val_1),
      .val             (rs1_val),
      .has_dep         (rs1_has_dep),
      .dep             (rs1_dep)
   );

   reg_read_port #(.ROB_W(ROB_W)) u_rd2 (
      .id              (rs2_id),
      .set_id          (set_id),
      .set_val         (set_val),
      .set_from_rob_id (set_from_rob_id),
      .busy            (busy_q[rs2_id]),
      .tag             (tag_q[rs2_id]),
      .reg_val         (val_q[rs2_id]),
      .rob_avail       (rob_avail_2),
      .rob_val         (rob_val_2),
      .val             (rs2_val),
      .has_dep         (rs2_has_dep),
      .dep             (rs2_dep)
   );
endmodule

// File: tb/tb_reg_file.sv
// Directed scenarios plus randomized traffic checked against an array-based reference model.
module tb_reg_file;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_clear;
   logic [4:0]  set_id, set_dep_id, rs1_id, rs2_id;
   logic [31:0] set_val, rob_val_1, rob_val_2;
   logic [2:0]  set_from_rob_id, set_dep_Q;
   logic        rob_avail_1, rob_avail_2;
   logic [2:0]  get_rob_id_1, get_rob_id_2, rs1_dep, rs2_dep;
   logic [31:0] rs1_val, rs2_val;
   logic        rs1_has_dep, rs2_has_dep;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [2:0]  m_tag  [32];

   reg_file dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .set_id(set_id), .set_val(set_val), .set_from_rob_id(set_from_rob_id),
      .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .get_rob_id_1(get_rob_id_1), .get_rob_id_2(get_rob_id_2),
      .rob_avail_1(rob_avail_1), .rob_avail_2(rob_avail_2),
      .rob_val_1(rob_val_1), .rob_val_2(rob_val_2),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_has_dep(rs1_has_dep), .rs2_has_dep(rs2_has_dep),
      .rs1_dep(rs1_dep), .rs2_dep(rs2_dep)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rst_in = 0; rdy_in = 1; rob_clear = 0;
      set_id = 0; set_val = 0; set_from_rob_id = 0;
      set_dep_id = 0; set_dep_Q = 0;
      rs1_id = 0; rs2_id = 0;
      rob_avail_1 = 0; rob_avail_2 = 0; rob_val_1 = 0; rob_val_2 = 0;
   endtask

   // Apply the architectural update rules for the inputs present at this edge.
   task automatic tick();
      @(posedge clk_in);
      if (rdy_in) begin
         if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
               m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
         end else if (rob_clear) begin
            for (int i = 0; i < 32; i++) begin
               m_busy[i] = 0; m_tag[i] = 0;
            end
         end else begin
            if (set_id != 0) begin
               m_val[set_id] = set_val;
               if (m_tag[set_id] == set_from_rob_id) m_busy[set_id] = 0;
            end
            if (set_dep_id != 0) begin
               m_busy[set_dep_id] = 1;
               m_tag[set_dep_id]  = set_dep_Q;
            end
         end
      end
      #1;
   endtask

   function automatic void model_read(input logic [4:0] id, input logic avail,
                                      input logic [31:0] rv, output logic [31:0] v,
                                      output logic hd, output logic [2:0] dp);
      v = 0; hd = 0; dp = 0;
      if (id == 0) v = 0;
      else if (set_id == id && m_busy[id] && m_tag[id] == set_from_rob_id) v = set_val;
      else if (m_busy[id] && avail) v = rv;
      else if (m_busy[id]) begin hd = 1; dp = m_tag[id]; end
      else v = m_val[id];
   endfunction

   task automatic check_model();
      logic [31:0] v; logic hd; logic [2:0] dp;
      model_read(rs1_id, rob_avail_1, rob_val_1, v, hd, dp);
      check("rnd_rs1_val", rs1_val, v);
      check("rnd_rs1_has_dep", 32'(rs1_has_dep), 32'(hd));
      check("rnd_rs1_dep", 32'(rs1_dep), 32'(dp));
      check("rnd_get_rob_id_1", 32'(get_rob_id_1), 32'(m_tag[rs1_id]));
      model_read(rs2_id, rob_avail_2, rob_val_2, v, hd, dp);
      check("rnd_rs2_val", rs2_val, v);
      check("rnd_rs2_has_dep", 32'(rs2_has_dep), 32'(hd));
      check("rnd_rs2_dep", 32'(rs2_dep), 32'(dp));
      check("rnd_get_rob_id_2", 32'(get_rob_id_2), 32'(m_tag[rs2_id]));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
      idle();
      // 1: reset
      rst_in = 1; tick(); idle();
      rs1_id = 5; rs2_id = 0; #2;
      check("rst_rs1_val", rs1_val, 0);
      check("rst_rs1_dep", 32'(rs1_has_dep), 0);
      check("rst_rs2_val", rs2_val, 0);
      check("rst_rs2_dep", 32'(rs2_has_dep), 0);
      // 2: rename then ROB bypass
      set_dep_id = 3; set_dep_Q = 2; tick(); idle();
      rs1_id = 3; #2;
      check("ren_get_rob_id", 32'(get_rob_id_1), 2);
      check("ren_has_dep", 32'(rs1_has_dep), 1);
      check("ren_dep", 32'(rs1_dep), 2);
      rob_avail_1 = 1; rob_val_1 = 32'h55; #2;
      check("rob_byp_val", rs1_val, 32'h55);
      check("rob_byp_dep", 32'(rs1_has_dep), 0);
      // 3: same-cycle commit bypass
      rob_avail_1 = 0; set_id = 3; set_val = 32'hAB; set_from_rob_id = 2; #2;
      check("cmt_byp_val", rs1_val, 32'hAB);
      check("cmt_byp_dep", 32'(rs1_has_dep), 0);
      tick(); idle(); rs1_id = 3; #2;
      check("cmt_val", rs1_val, 32'hAB);
      check("cmt_busy", 32'(rs1_has_dep), 0);
      // 4: commit and rename same reg, then stale commit
      set_dep_id = 3; set_dep_Q = 2; tick(); idle();
      set_id = 3; set_val = 32'hCD; set_from_rob_id = 2; set_dep_id = 3; set_dep_Q = 4;
      tick(); idle(); rs1_id = 3; #2;
      check("cr_has_dep", 32'(rs1_has_dep), 1);
      check("cr_dep", 32'(rs1_dep), 4);
      check("cr_get_rob_id", 32'(get_rob_id_1), 4);
      set_id = 3; set_val = 32'h11; set_from_rob_id = 1; tick(); idle(); rs1_id = 3; #2;
      check("stale_has_dep", 32'(rs1_has_dep), 1);
      rob_clear = 1; tick(); idle(); rs1_id = 3; #2;
      check("stale_val_kept", rs1_val, 32'h11);
      check("stale_cleared", 32'(rs1_has_dep), 0);
      // 5: flush with simultaneous commit
      set_id = 1; set_val = 32'h77; set_from_rob_id = 0; tick(); idle();
      for (int r = 1; r <= 4; r++) begin
         set_dep_id = 5'(r); set_dep_Q = 3'(r); tick();
      end
      idle(); rob_clear = 1; set_id = 1; set_val = 32'h99; set_from_rob_id = 1;
      tick(); idle();
      rs1_id = 1; rs2_id = 4; #2;
      check("clr_x1_val", rs1_val, 32'h77);
      check("clr_x1_dep", 32'(rs1_has_dep), 0);
      check("clr_x4_dep", 32'(rs2_has_dep), 0);
      rs2_id = 2; #2;
      check("clr_x2_dep", 32'(rs2_has_dep), 0);
      // 6: x0 writes and rdy_in hold
      set_id = 0; set_val = 32'hFFFF_FFFF; set_dep_id = 0; set_dep_Q = 5; tick(); idle();
      rs1_id = 0; #2;
      check("x0_val", rs1_val, 0);
      check("x0_dep", 32'(rs1_has_dep), 0);
      rdy_in = 0; set_dep_id = 7; set_dep_Q = 3; tick(); idle();
      rs1_id = 7; #2;
      check("hold_x7_dep", 32'(rs1_has_dep), 0);
      check("hold_x7_tag", 32'(get_rob_id_1), 0);
      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         rst_in          = ($urandom_range(0, 79) == 0);
         rdy_in          = ($urandom_range(0, 9) != 0);
         rob_clear       = ($urandom_range(0, 24) == 0);
         set_id          = 5'($urandom_range(0, 7));
         set_val         = $urandom;
         set_from_rob_id = 3'($urandom);
         set_dep_id      = 5'($urandom_range(0, 7));
         set_dep_Q       = 3'($urandom);
         rs1_id          = ($urandom_range(0, 3) == 0) ? set_id : 5'($urandom_range(0, 7));
         rs2_id          = 5'($urandom_range(0, 7));
         rob_avail_1     = 1'($urandom);
         rob_avail_2     = 1'($urandom);
         rob_val_1       = $urandom;
         rob_val_2       = $urandom;
         #2;
         check_model();
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
